// File: rtl/reg_file_sb.sv
// reg_file_sb: general-purpose register file with a per-register busy scoreboard.
// Two registered read ports with strobes, one write port with word/halfword/byte modes
// (zero- or sign-extending), same-cycle write-to-read bypass, and a busy bit per
// register for read-after-write hazard detection in decode. R0 reads as zero.
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_LEN = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_LEN-1:0] ra,
  input  logic [ADDR_LEN-1:0] rb,
  input  logic                r_en_A,
  input  logic                r_en_B,
  output logic [WIDTH-1:0]    dataA,
  output logic [WIDTH-1:0]    dataB,
  output logic                st_A,
  output logic                st_B,
  output logic                busy_A,
  output logic                busy_B,
  input  logic [ADDR_LEN-1:0] rc,
  input  logic [WIDTH-1:0]    dataC,
  input  logic                w_en,
  input  logic [2:0]          w_mode,
  input  logic                claim_en,
  input  logic [ADDR_LEN-1:0] claim_addr,
  input  logic                flush
);

  localparam logic [ADDR_LEN:0] NumRegsW = (ADDR_LEN + 1)'(NUM_REGS);

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic             wr_ok;
  logic             claim_ok;
  logic             rd_a_ok;
  logic             rd_b_ok;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH-1:0] data_a_d;
  logic [WIDTH-1:0] data_b_d;
  logic             busy_a_d;
  logic             busy_b_d;

  // Address is a real, writable register: in range and not the hardwired R0.
  function automatic logic addr_ok(input logic [ADDR_LEN-1:0] addr);
    return (addr != '0) && ({1'b0, addr} < NumRegsW);
  endfunction

  // Narrow the write data according to w_mode; loop form keeps WIDTH == 16 legal.
  function automatic logic [WIDTH-1:0] ext(input logic [WIDTH-1:0] d, input logic [2:0] m);
    logic [WIDTH-1:0] r;
    r = d;
    unique case (m)
      3'd1, 3'd3: begin
        for (int i = 16; i < WIDTH; i++) r[i] = (m == 3'd3) ? d[15] : 1'b0;
      end
      3'd2, 3'd4: begin
        for (int i = 8; i < WIDTH; i++) r[i] = (m == 3'd4) ? d[7] : 1'b0;
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Decode write/claim validity and the extended write value.
  always_comb begin
    wr_ok    = w_en && addr_ok(rc);
    claim_ok = claim_en && addr_ok(claim_addr);
    wr_val   = ext(dataC, w_mode);
  end

  // Scoreboard next state: flush beats everything, claim beats a same-address clear.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_ok)    busy_d[rc]         = 1'b0;
      if (claim_ok) busy_d[claim_addr] = 1'b1;
    end
  end

  // Read-port next values, with write bypass and post-update busy bits.
  always_comb begin
    rd_a_ok  = addr_ok(ra);
    rd_b_ok  = addr_ok(rb);
    data_a_d = '0;
    data_b_d = '0;
    busy_a_d = 1'b0;
    busy_b_d = 1'b0;
    if (rd_a_ok) begin
      data_a_d = (wr_ok && (rc == ra)) ? wr_val : regs_q[ra];
      busy_a_d = busy_d[ra];
    end
    if (rd_b_ok) begin
      data_b_d = (wr_ok && (rc == rb)) ? wr_val : regs_q[rb];
      busy_b_d = busy_d[rb];
    end
  end

  // Register array write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[rc] <= wr_val;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Port A output registers; data and busy hold while the port is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataA  <= '0;
      busy_A <= 1'b0;
      st_A   <= 1'b0;
    end else begin
      st_A <= r_en_A;
      if (r_en_A) begin
        dataA  <= data_a_d;
        busy_A <= busy_a_d;
      end
    end
  end

  // Port B output registers; data and busy hold while the port is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataB  <= '0;
      busy_B <= 1'b0;
      st_B   <= 1'b0;
    end else begin
      st_B <= r_en_B;
      if (r_en_B) begin
        dataB  <= data_b_d;
        busy_B <= busy_b_d;
      end
    end
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised general-purpose register file with a per-register busy scoreboard for the MyProc2 pipeline. It provides two synchronous read ports with strobes and one write port with word, halfword and byte modes, including sign-extending loads. Same-cycle writes bypass to the read ports. The scoreboard tracks registers with an outstanding write so that decode can stall on read-after-write hazards.

## Interface
- WIDTH, 32, data width in bits; must be ≥ 16.
- NUM_REGS, 32, number of registers; 2 ≤ NUM_REGS ≤ 2^ADDR_LEN.
- ADDR_LEN, 5, register address width.
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- ra, rb  in  ADDR_LEN  read addresses, port A / port B.
- r_en_A, r_en_B  in  1  read enables.
- dataA, dataB  out  WIDTH  registered read data.
- st_A, st_B  out  1  read-valid strobes.
- busy_A, busy_B  out  1  scoreboard bit of the register read, registered with the data.
- rc  in  ADDR_LEN  write address.
- dataC  in  WIDTH  write data.
- w_en  in  1  write enable; also clears the busy bit of rc.
- w_mode  in  3  write mode:
  - 0: word.
  - 1: halfword, zero-extend.
  - 2: byte, zero-extend.
  - 3: halfword, sign-extend.
  - 4: byte, sign-extend.
  - 5–7: treated as word.
- claim_en  in  1  set the busy bit of claim_addr (write issued).
- claim_addr  in  ADDR_LEN  register being claimed.
- flush  in  1  clear all busy bits (pipeline flush).

## Operation
- **Storage**
  - NUM_REGS × WIDTH data array plus a NUM_REGS-bit busy vector.
  - R0 is hardwired to zero:
    - writes to R0 are dropped;
    - claims of R0 are dropped;
    - reads of R0 return 0 with busy = 0.
- **Out-of-range addresses** (≥ NUM_REGS):
  - writes and claims are ignored;
  - reads return 0 with busy = 0.
- **Write path** (posedge, w_en = 1, rc valid and nonzero):
  - Stores ext(dataC, w_mode).
  - Zero-extension fills the upper bits with 0.
  - Sign-extension replicates dataC[15] (halfword) or dataC[7] (byte) up to WIDTH-1.
- **Read path** (posedge, r_en_X = 1):
  - dataX ← RegFile[rX].
  - If w_en = 1 and rc = rX ≠ 0 in the same cycle, dataX ← ext(dataC, w_mode) instead (bypass).
  - With r_en_X = 0, dataX and busy_X hold their previous values.
- **Scoreboard update order** within one edge:
  1. flush clears every bit, and claim is ignored in that cycle; otherwise go to steps 2 and 3.
  2. w_en clears busy[rc].
  3. claim_en sets busy[claim_addr]; a claim wins over a clear to the same address.
- **busy_X**: with r_en_X = 1, busy_X ← busy[rX] after the update above, so a same-cycle claim of rX reads back as busy.
- Ports A and B are fully independent and may address the same register.

## Timing
- **Reset** (rst_n low, asynchronous) forces to 0:
  - all registers and all busy bits;
  - dataA, dataB, st_A, st_B, busy_A, busy_B.
- Release is synchronous to the next posedge. Reset asserted mid-access aborts it, and the strobe is 0 on that edge.
- **Read latency**: 1 cycle. r_en_X sampled at edge N gives dataX, busy_X and st_X = 1 valid after edge N.
- **Strobe**: st_X ← r_en_X at every posedge.
  - Back-to-back enables give st_X high continuously.
  - Each cycle carries the data for the address sampled at the prior edge.
- **Write latency**: 1 cycle. A non-bypassed read issued on the edge after the write returns the new value.
- **Scoreboard latency**:
  - A claim at edge N is visible to reads sampled at edge N via the bypass rule.
  - A clear at edge N reads back as not busy at edge N.
- No back-pressure; every enabled access completes in one cycle.

## Test plan
- Reset, then read every register on both ports → all dataX = 0, busy_X = 0, st_X = 1 one cycle after each enable.
- Write R5 = 0xDEADBEEF in word mode, then read A = 5, B = 0 → dataA = 0xDEADBEEF, dataB = 0.
- Write R3 with dataC = 0x0000_8081 in each mode and read back:
  - mode 1 → 0x00008081;
  - mode 2 → 0x00000081;
  - mode 3 → 0xFFFF8081;
  - mode 4 → 0xFFFFFF81.
- Same-cycle write R7 = 0x12345678 with read A = 7 → dataA = 0x12345678 after that edge (bypass); R0 write of 0xFFFFFFFF reads 0.
- Scoreboard:
  - claim R9, then read → busy_A = 1;
  - write R9 plus claim R9 in the same cycle → busy stays 1;
  - write R9 alone → busy 0;
  - claims of R2 and R4 then flush → both reads show busy 0.
- Assert rst_n low mid-stream with registers written and busy set → outputs drop to 0 immediately, without a clock edge; after release, reads return 0 and not busy.
